// File: rtl/mem_ctrl_pkg.sv
// Shared encodings, constants and byte-lane helpers for the memory port
// arbiter/sequencer.
package mem_ctrl_pkg;
    localparam logic        Enable   = 1'b1;
    localparam logic        Disable  = 1'b0;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    localparam logic [2:0]  WordLen  = 3'd4;

    typedef enum logic [1:0] {
        MemIdle  = 2'd0,
        MemRead  = 2'd1,
        MemWrite = 2'd2,
        MemDone  = 2'd3
    } mem_state_e;

    typedef enum logic {
        OwnerIf = 1'b0,
        OwnerLs = 1'b1
    } owner_e;

    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = word;
        r[{lane, 3'b000} +: 8] = b;
        return r;
    endfunction
endpackage

// File: rtl/mem_ctrl.sv
// Arbiter and byte sequencer sharing the byte-wide RAM/IO port between
// instruction fetch and the load/store buffer.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] IO_ADDR_LO = 32'h0003_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_done_o,
    output logic [31:0] if_inst_o,
    input  logic        ls_req_i,
    input  logic        ls_wr_i,
    input  logic [2:0]  ls_len_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_data_i,
    output logic        ls_done_o,
    output logic [31:0] ls_data_o,
    input  logic [7:0]  mem_din_i,
    output logic [7:0]  mem_dout_o,
    output logic [31:0] mem_a_o,
    output logic        mem_wr_o,
    input  logic        io_buffer_full_i
);
    mem_state_e  state, state_nxt;
    owner_e      owner;
    logic [2:0]  len_q, cnt, cnt_m1;
    logic [31:0] addr_q, data_q, result, cap_word;
    logic        rdy_d;
    logic [7:0]  din_save, din_eff;
    logic        grant, stall, last_wr, last_rd;

    assign grant   = !clear_i && (ls_req_i || if_req_i);
    assign stall   = (state == MemWrite) && io_buffer_full_i && (addr_q >= IO_ADDR_LO);
    assign last_wr = (cnt == len_q - 3'd1);
    assign last_rd = (cnt == len_q);
    assign cnt_m1  = cnt - 3'd1;

    // The RAM keeps answering the held address during a freeze, so the byte
    // that belonged to the frozen cycle is kept aside and used on resume.
    assign din_eff  = rdy_d ? mem_din_i : din_save;
    assign cap_word = put_byte(result, cnt_m1[1:0], din_eff);

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_d <= Enable;
        end else begin
            rdy_d <= rdy;
        end
        if (rdy_d) begin
            din_save <= mem_din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MemIdle;
        end else if (rdy) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MemIdle: begin
                if (grant) begin
                    state_nxt = (ls_req_i && ls_wr_i) ? MemWrite : MemRead;
                end
            end
            MemRead: begin
                if (clear_i) begin
                    state_nxt = MemIdle;
                end else if (last_rd) begin
                    state_nxt = MemDone;
                end
            end
            MemWrite: begin
                if (!stall && last_wr) begin
                    state_nxt = MemDone;
                end
            end
            default: state_nxt = MemIdle;
        endcase
    end

    // The final read cycle only captures; no address goes out, so an IO
    // location is never read one byte past the request.
    always_comb begin
        mem_a_o    = ZeroWord;
        mem_wr_o   = Disable;
        mem_dout_o = 8'h00;
        case (state)
            MemRead: begin
                if (!last_rd) begin
                    mem_a_o = addr_q + {29'd0, cnt};
                end
            end
            MemWrite: begin
                if (!stall) begin
                    mem_a_o    = addr_q + {29'd0, cnt};
                    mem_wr_o   = rdy;
                    mem_dout_o = get_byte(data_q, cnt[1:0]);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rdy) begin
            case (state)
                MemIdle: begin
                    if (grant) begin
                        cnt    <= 3'd0;
                        result <= ZeroWord;
                        if (ls_req_i) begin
                            owner  <= OwnerLs;
                            len_q  <= ls_len_i;
                            addr_q <= ls_addr_i;
                            data_q <= ls_data_i;
                        end else begin
                            owner  <= OwnerIf;
                            len_q  <= WordLen;
                            addr_q <= if_addr_i;
                            data_q <= ZeroWord;
                        end
                    end
                end
                MemRead: begin
                    if (cnt != 3'd0) begin
                        result <= cap_word;
                    end
                    if (!last_rd) begin
                        cnt <= cnt + 3'd1;
                    end
                end
                MemWrite: begin
                    if (!stall) begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_done_o <= Disable;
            ls_done_o <= Disable;
            if_inst_o <= ZeroWord;
            ls_data_o <= ZeroWord;
        end else if (rdy) begin
            if_done_o <= Disable;
            ls_done_o <= Disable;
            if (state != MemDone && state_nxt == MemDone) begin
                if (owner == OwnerIf) begin
                    if_done_o <= Enable;
                    if (state == MemRead) begin
                        if_inst_o <= cap_word;
                    end
                end else begin
                    ls_done_o <= Enable;
                    if (state == MemRead) begin
                        ls_data_o <= cap_word;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized self-checking bench for mem_ctrl against a transaction-level
// memory model.
module tb_mem_ctrl;
    localparam logic [31:0] IO_LO = 32'h0003_0000;

    logic        clk = 1'b0;
    logic        rst, rdy, clear_i;
    logic        if_req_i, ls_req_i, ls_wr_i, io_buffer_full_i;
    logic [2:0]  ls_len_i;
    logic [31:0] if_addr_i, ls_addr_i, ls_data_i;
    logic [7:0]  mem_din_i;
    logic        if_done_o, ls_done_o, mem_wr_o;
    logic [31:0] if_inst_o, ls_data_o, mem_a_o;
    logic [7:0]  mem_dout_o;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] env_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    mem_ctrl #(.IO_ADDR_LO(IO_LO)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear_i(clear_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_done_o(if_done_o), .if_inst_o(if_inst_o),
        .ls_req_i(ls_req_i), .ls_wr_i(ls_wr_i), .ls_len_i(ls_len_i), .ls_addr_i(ls_addr_i),
        .ls_data_i(ls_data_i), .ls_done_o(ls_done_o), .ls_data_o(ls_data_o),
        .mem_din_i(mem_din_i), .mem_dout_o(mem_dout_o), .mem_a_o(mem_a_o), .mem_wr_o(mem_wr_o),
        .io_buffer_full_i(io_buffer_full_i)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] env_rd(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    // Byte-wide synchronous RAM: one cycle read latency, write on the edge.
    always @(posedge clk) begin
        if (mem_wr_o) env_mem[mem_a_o] = mem_dout_o;
        mem_din_i <= env_rd(mem_a_o);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        if_req_i = 1'b0; ls_req_i = 1'b0; clear_i = 1'b0;
        io_buffer_full_i = 1'b0; rdy = 1'b1;
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        env_mem[a] = b;
        ref_mem[a] = b;
    endtask

    // One request from grant to done; expectations come from the byte-level
    // memory image and the cycle-count rules of the port.
    task automatic xact(input bit is_if, input bit wr, input int len, input logic [31:0] addr,
                        input logic [31:0] data, input int full_cyc, input int frz_at,
                        input int frz_len, input int clr_at);
        logic [31:0] exp_val, wa[$];
        logic [7:0]  wd[$];
        int          exp_cyc, got_cyc, other, shift;
        bit          abort, req;
        exp_val = 32'h0;
        for (int i = 0; i < len; i++) exp_val[8*i +: 8] = ref_rd(addr + 32'(i));
        abort   = !wr && clr_at >= 1 && clr_at <= len + 1;
        shift   = (clr_at == 0) ? 1 : 0;
        exp_cyc = (wr ? len + 1 : len + 2) + shift + frz_len
                  + ((wr && addr >= IO_LO) ? full_cyc : 0);
        got_cyc = -1;
        other   = 0;
        for (int cyc = 0; cyc < 48; cyc++) begin
            step();
            req = !(abort && cyc > clr_at);
            if_req_i  = is_if && req;
            ls_req_i  = !is_if && req;
            if_addr_i = addr;
            ls_addr_i = addr;
            ls_wr_i   = wr;
            ls_len_i  = 3'(len);
            ls_data_i = data;
            clear_i   = (cyc == clr_at);
            rdy       = !(cyc >= frz_at && cyc < frz_at + frz_len);
            io_buffer_full_i = (cyc >= 1 && cyc <= full_cyc);
            #1;
            if (mem_wr_o) begin
                wa.push_back(mem_a_o);
                wd.push_back(mem_dout_o);
            end
            if (!wr && frz_len == 0 && cyc >= 1 + shift && cyc <= len + shift && !(abort && cyc > clr_at))
                chk("rd_addr", mem_a_o, addr + 32'(cyc - 1 - shift));
            if (wr && addr >= IO_LO && cyc >= 1 && cyc <= full_cyc)
                chk("stall_addr", mem_a_o, 32'h0);
            if (abort && cyc == clr_at + 1)
                chk("abort_idle", mem_a_o, 32'h0);
            if (is_if ? ls_done_o : if_done_o) other++;
            if (is_if ? if_done_o : ls_done_o) begin
                got_cyc = cyc;
                break;
            end
            if (abort && cyc == clr_at + 3) break;
        end
        chk("other_done", 32'(other), 32'h0);
        if (abort) begin
            chk("abort_done", 32'(got_cyc), 32'hFFFF_FFFF);
            chk("abort_nowrite", 32'(wa.size()), 32'h0);
        end else if (!wr) begin
            chk("latency", 32'(got_cyc), 32'(exp_cyc));
            chk("rd_data", is_if ? if_inst_o : ls_data_o, exp_val);
            chk("rd_nowrite", 32'(wa.size()), 32'h0);
        end else begin
            chk("latency", 32'(got_cyc), 32'(exp_cyc));
            chk("wr_count", 32'(wa.size()), 32'(len));
            for (int i = 0; i < len && i < wa.size(); i++) begin
                chk("wr_addr", wa[i], addr + 32'(i));
                chk("wr_byte", {24'h0, wd[i]}, {24'h0, data[8*i +: 8]});
            end
            for (int i = 0; i < len; i++) ref_mem[addr + 32'(i)] = data[8*i +: 8];
            for (int i = 0; i <= len; i++)
                chk("mem_byte", {24'h0, env_rd(addr + 32'(i))}, {24'h0, ref_rd(addr + 32'(i))});
        end
    endtask

    initial begin
        int ls_at, if_at, kind, len, lsel, region, full_cyc, frz_at, frz_len, clr_at;
        logic [31:0] addr;
        rst = 1'b1;
        set_idle();
        if_addr_i = 32'h0; ls_addr_i = 32'h0; ls_data_i = 32'h0; ls_len_i = 3'd0; ls_wr_i = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("reset_addr", mem_a_o, 32'h0);
        chk("reset_ctl", {28'h0, mem_wr_o, if_done_o, ls_done_o, |mem_dout_o}, 32'h0);
        chk("reset_inst", if_inst_o, 32'h0);
        chk("reset_ldata", ls_data_o, 32'h0);

        poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
        poke(32'h200, 8'hEF); poke(32'h201, 8'hBE); poke(32'h202, 8'hAD); poke(32'h203, 8'hDE);
        xact(1, 0, 4, 32'h100, 32'h0, 0, 0, 0, -1);
        chk("fetch_word", if_inst_o, 32'h0000_0513);

        // Simultaneous IF and LW: LS first, IF granted right after LS completes.
        ls_at = -1; if_at = -1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            step();
            set_idle();
            ls_req_i = (ls_at < 0); ls_wr_i = 1'b0; ls_len_i = 3'd4; ls_addr_i = 32'h200;
            if_req_i = (if_at < 0); if_addr_i = 32'h100;
            #1;
            if (ls_done_o && ls_at < 0) ls_at = cyc;
            if (if_done_o && if_at < 0) begin
                if_at = cyc;
                break;
            end
        end
        chk("prio_ls_cyc", 32'(ls_at), 32'd6);
        chk("prio_if_cyc", 32'(if_at), 32'd13);
        chk("prio_ls_data", ls_data_o, 32'hDEAD_BEEF);
        chk("prio_if_data", if_inst_o, 32'h0000_0513);

        xact(0, 1, 2, 32'h1000, 32'h0000_ABCD, 0, 0, 0, -1);
        xact(0, 1, 1, 32'h3_0000, 32'h41, 3, 0, 0, -1);
        xact(0, 1, 1, 32'h2_FFFF, 32'h77, 3, 0, 0, -1);
        xact(1, 0, 4, 32'h100, 32'h0, 0, 0, 0, 3);
        xact(1, 0, 4, 32'h200, 32'h0, 0, 0, 0, -1);
        chk("refetch_word", if_inst_o, 32'hDEAD_BEEF);
        xact(1, 0, 4, 32'h100, 32'h0, 0, 3, 2, -1);

        // Reset in the middle of a SW: two bytes land, everything else clears.
        for (int cyc = 0; cyc < 4; cyc++) begin
            step();
            set_idle();
            ls_req_i = (cyc <= 2); ls_wr_i = 1'b1; ls_len_i = 3'd4;
            ls_addr_i = 32'h2000; ls_data_i = 32'h1122_3344;
            rst = (cyc == 2);
            #1;
            if (cyc == 3) begin
                chk("rst_addr", mem_a_o, 32'h0);
                chk("rst_ctl", {24'h0, mem_dout_o}, {31'h0, mem_wr_o | if_done_o | ls_done_o} ^ 32'h0);
                chk("rst_inst", if_inst_o, 32'h0);
                chk("rst_ldata", ls_data_o, 32'h0);
            end
        end
        ref_mem[32'h2000] = 8'h44;
        ref_mem[32'h2001] = 8'h33;
        for (int i = 0; i < 3; i++)
            chk("rst_mem", {24'h0, env_rd(32'h2000 + 32'(i))}, {24'h0, ref_rd(32'h2000 + 32'(i))});

        for (int t = 0; t < 60; t++) begin
            kind   = int'($urandom_range(0, 2));
            lsel   = int'($urandom_range(0, 2));
            len    = (kind == 0) ? 4 : ((lsel == 2) ? 4 : lsel + 1);
            region = int'($urandom_range(0, 2));
            addr   = (region == 0) ? 32'h1000 + $urandom_range(0, 63) :
                     (region == 1) ? IO_LO - 32'd2 + $urandom_range(0, 5) :
                                     32'hFFFF_FFFC + $urandom_range(0, 3);
            full_cyc = (kind == 2) ? int'($urandom_range(0, 3)) : 0;
            frz_at = 0; frz_len = 0; clr_at = -1;
            if (kind != 2 && $urandom_range(0, 3) == 0) begin
                frz_len = int'($urandom_range(1, 2));
                frz_at  = int'($urandom_range(1, len + 1));
            end
            if (frz_len == 0 && full_cyc == 0 && $urandom_range(0, 3) == 0)
                clr_at = int'($urandom_range(0, len + 2));
            if ($urandom_range(0, 1) == 1) begin
                step();
                set_idle();
            end
            xact(kind == 0, kind == 2, len, addr, $urandom, full_cyc, frz_at, frz_len, clr_at);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
